clk_divider: RTL



---
 rtl/clk_divider.sv | 70 +++++++
 1 files changed

// File: rtl/clk_divider.sv
// Multi-channel programmable clock divider: each channel emits a registered,
// near-50% duty clock of period div_i cycles plus a period-start strobe.
module clk_divider #(
    parameter int CH    = 2,
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CH-1:0]         en_i,
    input  logic [CH*WIDTH-1:0]   div_i,
    output logic [CH-1:0]         clk_o,
    output logic [CH-1:0]         tick_o
);

    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

    // One extra bit so (p+1) cannot overflow at the maximum divisor.
    function automatic logic [WIDTH:0] high_time(input logic [WIDTH-1:0] p);
        return ({1'b0, p} + 1'b1) >> 1;
    endfunction

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] p;
        logic             run;
        logic             clk_r;
        logic             tick_r;
        logic [WIDTH-1:0] div_k;
        logic [WIDTH:0]   cnt_nxt;
        logic             start_ok;
        logic             last;

        assign div_k    = div_i[k*WIDTH +: WIDTH];
        assign cnt_nxt  = {1'b0, cnt} + 1'b1;
        assign start_ok = en_i[k] && (div_k >= DIV_MIN);
        assign last     = (cnt == p - 1'b1);

        // Inputs are only looked at when idle or on the final cycle of a period,
        // so a period in flight always finishes with its latched divisor.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt    <= '0;
                p      <= '0;
                run    <= 1'b0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (!run || last) begin
                cnt <= '0;
                if (start_ok) begin
                    p      <= div_k;
                    run    <= 1'b1;
                    clk_r  <= 1'b1;
                    tick_r <= 1'b1;
                end else begin
                    run    <= 1'b0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end
            end else begin
                cnt    <= cnt_nxt[WIDTH-1:0];
                clk_r  <= (cnt_nxt < high_time(p));
                tick_r <= 1'b0;
            end
        end

        assign clk_o[k]  = clk_r;
        assign tick_o[k] = tick_r;
    end

endmodule
